// File: rtl/natv_mbox_pkg.sv
// natv_mbox_pkg: shared constants for the native-bus mailbox.
//   - Register offsets as decoded from addr[3:2].
//   - STATUS and CTRL bit positions.
//   - Bus FSM state encoding.
package natv_mbox_pkg;

    localparam logic [1:0] MBOX_DATA = 2'd0;
    localparam logic [1:0] MBOX_STAT = 2'd1;
    localparam logic [1:0] MBOX_CTRL = 2'd2;
    localparam logic [1:0] MBOX_LVL  = 2'd3;

    // STATUS bits
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_OVF      = 4;
    localparam int STAT_UNF      = 5;

    // CTRL bits
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_TX_FLUSH  = 8;
    localparam int CTRL_RX_FLUSH  = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } mbox_state_e;

endpackage

// File: rtl/natv_mbox_if.sv
// natv_mbox_if: native valid/ready request bus between the core wrapper
// (master) and a responder slot (slave).
//   natv_valid_i  request valid, held until natv_ready_o
//   natv_addr_i   byte address
//   natv_wdata_i  write data
//   natv_wstrb_i  byte strobes, all zero means read
//   natv_rdata_o  read data, valid with natv_ready_o
//   natv_ready_o  one-cycle response pulse
interface natv_mbox_if;

    logic        natv_valid_i;
    logic [31:0] natv_addr_i;
    logic [31:0] natv_wdata_i;
    logic [3:0]  natv_wstrb_i;
    logic [31:0] natv_rdata_o;
    logic        natv_ready_o;

    modport master (
        output natv_valid_i,
        output natv_addr_i,
        output natv_wdata_i,
        output natv_wstrb_i,
        input  natv_rdata_o,
        input  natv_ready_o
    );

    modport slave (
        input  natv_valid_i,
        input  natv_addr_i,
        input  natv_wdata_i,
        input  natv_wstrb_i,
        output natv_rdata_o,
        output natv_ready_o
    );

endinterface

// File: rtl/natv_mbox_fifo.sv
// mbox_fifo: synchronous FIFO with push/pop/flush used for both mailbox
// directions.
//   clk_i, rst_i   clock, synchronous active-high reset
//   i_push/i_data  write request and data (ignored when full)
//   i_pop          read request (ignored when empty)
//   i_flush        empties the FIFO; overrides push/pop in the same cycle
//   o_head         entry at the read pointer, zero when empty
//   o_full/o_empty status from the current count
//   o_count        current occupancy
//   o_empty_nxt    emptiness after this cycle's update
module mbox_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [DW-1:0]              o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic [AW:0]   w_count_nxt;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // Full/empty come from the count at the start of the cycle, so a push
    // to a full FIFO is refused even if a pop happens in the same cycle.
    assign w_do_push = i_push & ~w_full  & ~i_flush;
    assign w_do_pop  = i_pop  & ~w_empty & ~i_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_count     = r_count;
    assign o_empty_nxt = (w_count_nxt == '0);

endmodule

// File: rtl/natv_mbox.sv
// natv_mbox: native-bus mailbox bridging core register accesses to a TX and
// an RX byte stream, with status, control and a level interrupt.
//   clk_i, rst_i      clock, synchronous active-high reset
//   bus               native request bus (slave side)
//   tx_valid_o/data_o TX stream head, tx_ready_i consumer accept
//   rx_valid_i/data_i RX stream producer, rx_ready_o = RX not full
//   irq_o             registered level interrupt
module natv_mbox
    import natv_mbox_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    natv_mbox_if.slave    bus,
    output logic          tx_valid_o,
    output logic [DW-1:0] tx_data_o,
    input  logic          tx_ready_i,
    input  logic          rx_valid_i,
    input  logic [DW-1:0] rx_data_i,
    output logic          rx_ready_o,
    output logic          irq_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    mbox_state_e   r_state;
    mbox_state_e   w_state_nxt;
    logic          w_commit;

    logic [31:0]   r_rdata;
    logic          r_rx_irq_en;
    logic          r_tx_irq_en;
    logic          r_ovf;
    logic          r_unf;
    logic          r_irq;

    logic [1:0]    w_addr;
    logic          w_wr;
    logic          w_tx_push;
    logic          w_rx_pop;
    logic          w_stat_wr;
    logic          w_ctrl_wr_lo;
    logic          w_tx_flush;
    logic          w_rx_flush;
    logic          w_rx_irq_en_nxt;
    logic          w_tx_irq_en_nxt;
    logic [31:0]   w_rdata;

    logic [DW-1:0] w_tx_head;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count;
    logic          w_tx_empty_nxt;

    logic [DW-1:0] w_rx_head;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [CW-1:0] w_rx_count;
    logic          w_rx_empty_nxt;

    logic          w_unused;

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.natv_valid_i) begin
                    w_commit    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset is synchronous, so the state is still RESP during a reset cycle;
    // masking with rst_i keeps an aborted request from pulsing ready.
    assign bus.natv_ready_o = (r_state == RESP) & ~rst_i;
    assign bus.natv_rdata_o = r_rdata;

    // ---------------- decode ----------------
    assign w_addr       = bus.natv_addr_i[3:2];
    assign w_wr         = |bus.natv_wstrb_i;
    assign w_tx_push    = w_commit & w_wr & (w_addr == MBOX_DATA) & bus.natv_wstrb_i[0];
    assign w_rx_pop     = w_commit & ~w_wr & (w_addr == MBOX_DATA);
    assign w_stat_wr    = w_commit & w_wr & (w_addr == MBOX_STAT) & bus.natv_wstrb_i[0];
    assign w_ctrl_wr_lo = w_commit & w_wr & (w_addr == MBOX_CTRL) & bus.natv_wstrb_i[0];
    assign w_tx_flush   = w_commit & w_wr & (w_addr == MBOX_CTRL) & bus.natv_wstrb_i[1]
                          & bus.natv_wdata_i[CTRL_TX_FLUSH];
    assign w_rx_flush   = w_commit & w_wr & (w_addr == MBOX_CTRL) & bus.natv_wstrb_i[1]
                          & bus.natv_wdata_i[CTRL_RX_FLUSH];

    assign w_rx_irq_en_nxt = w_ctrl_wr_lo ? bus.natv_wdata_i[CTRL_RX_IRQ_EN] : r_rx_irq_en;
    assign w_tx_irq_en_nxt = w_ctrl_wr_lo ? bus.natv_wdata_i[CTRL_TX_IRQ_EN] : r_tx_irq_en;

    // ---------------- FIFOs ----------------
    mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_push      (w_tx_push),
        .i_data      (bus.natv_wdata_i[DW-1:0]),
        .i_pop       (tx_ready_i),
        .i_flush     (w_tx_flush),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_count     (w_tx_count),
        .o_empty_nxt (w_tx_empty_nxt)
    );

    mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_push      (rx_valid_i),
        .i_data      (rx_data_i),
        .i_pop       (w_rx_pop),
        .i_flush     (w_rx_flush),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count),
        .o_empty_nxt (w_rx_empty_nxt)
    );

    assign tx_valid_o = ~w_tx_empty;
    assign tx_data_o  = w_tx_head;
    assign rx_ready_o = ~w_rx_full;

    // ---------------- read mux ----------------
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            MBOX_DATA: w_rdata[DW-1:0] = w_rx_head;
            MBOX_STAT: begin
                w_rdata[STAT_TX_FULL]  = w_tx_full;
                w_rdata[STAT_TX_EMPTY] = w_tx_empty;
                w_rdata[STAT_RX_FULL]  = w_rx_full;
                w_rdata[STAT_RX_EMPTY] = w_rx_empty;
                w_rdata[STAT_OVF]      = r_ovf;
                w_rdata[STAT_UNF]      = r_unf;
            end
            MBOX_CTRL: begin
                w_rdata[CTRL_RX_IRQ_EN] = r_rx_irq_en;
                w_rdata[CTRL_TX_IRQ_EN] = r_tx_irq_en;
            end
            MBOX_LVL: begin
                w_rdata[CW-1:0]  = w_tx_count;
                w_rdata[8 +: CW] = w_rx_count;
            end
            default: w_rdata = '0;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata     <= '0;
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_commit) r_rdata <= w_wr ? '0 : w_rdata;
            r_rx_irq_en <= w_rx_irq_en_nxt;
            r_tx_irq_en <= w_tx_irq_en_nxt;

            if (w_tx_push & w_tx_full)
                r_ovf <= 1'b1;
            else if (w_stat_wr & bus.natv_wdata_i[STAT_OVF])
                r_ovf <= 1'b0;

            if (w_rx_pop & w_rx_empty)
                r_unf <= 1'b1;
            else if (w_stat_wr & bus.natv_wdata_i[STAT_UNF])
                r_unf <= 1'b0;

            // Evaluated on the state this edge produces, not the old state.
            r_irq <= (w_rx_irq_en_nxt & ~w_rx_empty_nxt) | (w_tx_irq_en_nxt & w_tx_empty_nxt);
        end
    end

    assign irq_o = r_irq;

    assign w_unused = ^{bus.natv_addr_i[31:4], bus.natv_addr_i[1:0], bus.natv_wdata_i[31:10]};

endmodule

// File: tb/tb_natv_mbox.sv
module tb_natv_mbox;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ready;
    logic       irq;

    int checks = 0;
    int errors = 0;
    int rsp_no = 0;

    // bit 32 = compare enable, [31:0] = expected read data
    logic [32:0] exp_q[$];

    natv_mbox_if bus();

    natv_mbox #(.DEPTH(8), .DW(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ready pulse consumes one expected entry.
    always @(negedge clk) begin
        if (bus.natv_ready_o === 1'b1) begin
            logic [32:0] e;
            rsp_no++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: rsp %0d rdata 0x%08h with nothing pending",
                         rsp_no, bus.natv_rdata_o);
            end else begin
                e = exp_q.pop_front();
                if (e[32]) chk($sformatf("bus_rd#%0d", rsp_no), bus.natv_rdata_o, e[31:0]);
            end
        end
    end

    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            input logic do_chk, input logic [31:0] exp);
        bit got;
        exp_q.push_back({do_chk, exp});
        @(negedge clk);
        bus.natv_valid_i = 1'b1;
        bus.natv_addr_i  = a;
        bus.natv_wstrb_i = s;
        bus.natv_wdata_i = d;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.natv_ready_o === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: addr 0x%08h got no ready expected within 8 cycles", a);
            void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        bus.natv_valid_i = 1'b0;
        bus.natv_wstrb_i = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        bus_xfer(a, 4'h0, 32'h0, 1'b1, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_xfer(a, 4'hF, d, 1'b0, 32'h0);
    endtask

    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_LVL  = 32'hC;

    initial begin
        bus.natv_valid_i = 1'b0;
        bus.natv_addr_i  = '0;
        bus.natv_wdata_i = '0;
        bus.natv_wstrb_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.natv_ready_o), 0);
        chk("rst_rdata", bus.natv_rdata_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rx_ready", 32'(rx_ready), 1);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        rd(A_STAT, 32'h0000_000A);
        rd(A_LVL,  32'h0);
        rd(A_CTRL, 32'h0);

        // TX push and stream drain
        wr(A_DATA, 32'h41);
        wr(A_DATA, 32'h42);
        rd(A_LVL, 32'h0002);
        @(negedge clk);
        chk("tx_valid_two", 32'(tx_valid), 1);
        chk("tx_head_41", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_head_42", 32'(tx_data), 32'h42);
        chk("tx_valid_one", 32'(tx_valid), 1);
        @(negedge clk);
        chk("tx_drained_valid", 32'(tx_valid), 0);
        chk("tx_drained_data", 32'(tx_data), 0);
        tx_ready = 1'b0;

        // TX overflow, sticky OVF, clear, flush
        for (int i = 1; i <= 9; i++) wr(A_DATA, 32'(i));
        rd(A_LVL, 32'h0008);
        rd(A_STAT, 32'h0000_0019);
        @(negedge clk);
        chk("tx_head_after_ovf", 32'(tx_data), 32'h01);
        wr(A_STAT, 32'h10);
        rd(A_STAT, 32'h0000_0009);
        wr(A_CTRL, 32'h100);
        rd(A_LVL, 32'h0);
        rd(A_CTRL, 32'h0);
        bus_xfer(A_DATA, 4'b0010, 32'hAB, 1'b0, 32'h0);
        rd(A_LVL, 32'h0);

        // TX-empty interrupt
        wr(A_CTRL, 32'h2);
        @(negedge clk);
        chk("irq_tx_empty", 32'(irq), 1);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        chk("irq_rx_only_empty", 32'(irq), 0);

        // RX stream in, interrupt, pop, underflow
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("irq_rx_data", 32'(irq), 1);
        rd(A_DATA, 32'h55);
        @(negedge clk);
        chk("irq_after_pop", 32'(irq), 0);
        rd(A_DATA, 32'h0);
        rd(A_STAT, 32'h0000_002A);
        wr(A_STAT, 32'h20);
        rd(A_STAT, 32'h0000_000A);

        // RX fill to full, pop while producer is blocked, flush
        wr(A_CTRL, 32'h0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h60;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            rx_data = 8'h60 + 8'(i);
        end
        @(negedge clk);
        rx_data = 8'h70;
        chk("rx_full_ready", 32'(rx_ready), 0);
        rd(A_LVL, 32'h0800);
        exp_q.push_back({1'b1, 32'h60});
        @(negedge clk);
        bus.natv_valid_i = 1'b1;
        bus.natv_addr_i  = A_DATA;
        bus.natv_wstrb_i = 4'h0;
        @(negedge clk);
        chk("rx_ready_after_pop", 32'(rx_ready), 1);
        rx_valid = 1'b0;
        @(posedge clk);
        #1 bus.natv_valid_i = 1'b0;
        rd(A_LVL, 32'h0700);
        rd(A_DATA, 32'h61);
        rd(A_LVL, 32'h0600);
        wr(A_CTRL, 32'h200);
        rd(A_LVL, 32'h0);
        @(negedge clk);
        chk("rx_ready_after_flush", 32'(rx_ready), 1);

        // Reset during RESP
        wr(A_CTRL, 32'h3);
        @(negedge clk);
        chk("irq_both_en", 32'(irq), 1);
        wr(A_DATA, 32'h77);
        @(negedge clk);
        bus.natv_valid_i = 1'b1;
        bus.natv_addr_i  = A_DATA;
        bus.natv_wstrb_i = 4'hF;
        bus.natv_wdata_i = 32'h99;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_resp_ready", 32'(bus.natv_ready_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.natv_valid_i = 1'b0;
        bus.natv_wstrb_i = '0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.natv_ready_o), 0);
        chk("post_rst_tx_valid", 32'(tx_valid), 0);
        chk("post_rst_irq", 32'(irq), 0);
        chk("post_rst_rx_ready", 32'(rx_ready), 1);
        rd(A_STAT, 32'h0000_000A);
        rd(A_CTRL, 32'h0);
        rd(A_LVL, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end before 200us");
        $fatal(1);
    end

endmodule
